// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes, ALU selects, instruction field positions and core state
package cpu_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_PC_W   = 32;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;
    localparam logic [7:0] OP_J     = 8'd6;
    localparam logic [7:0] OP_BEQ   = 8'd7;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 24;
    localparam int DEST_MSB = 23;
    localparam int DEST_LSB = 16;
    localparam int SRC1_MSB = 15;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_MSB = 7;
    localparam int SRC2_LSB = 0;

    typedef enum logic {RUN, HALT} state_e;

endpackage

// File: rtl/cpu_if.sv
// cpu_if: instruction fetch and ALU operand/result bus between cpu_core and its surroundings
interface cpu_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 32
);
    logic [31:0]       INSTRUCTION;
    logic [PC_W-1:0]   PC;
    logic [DATA_W-1:0] OPERAND1;
    logic [DATA_W-1:0] OPERAND2;
    logic [2:0]        ALUOP;
    logic [DATA_W-1:0] ALURESULT;
    logic              HALTED;

    modport master (
        input  INSTRUCTION, ALURESULT,
        output PC, OPERAND1, OPERAND2, ALUOP, HALTED
    );

    modport slave (
        output INSTRUCTION, ALURESULT,
        input  PC, OPERAND1, OPERAND2, ALUOP, HALTED
    );
endinterface

// File: rtl/alu.sv
// alu: 8-bit combinational ALU (forward OPERAND2, add, and, or)
module alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] OPERAND1,
    input  logic [DATA_W-1:0] OPERAND2,
    input  logic [2:0]        ALUOP,
    output logic [DATA_W-1:0] ALURESULT
);
    // result select; unused selects produce zero
    always_comb begin
        ALURESULT = ALUOP == 3'b000 ? OPERAND2 :
                    ALUOP == 3'b001 ? OPERAND1 + OPERAND2 :
                    ALUOP == 3'b010 ? OPERAND1 & OPERAND2 :
                    ALUOP == 3'b011 ? OPERAND1 | OPERAND2 : '0;
    end
endmodule

// File: rtl/reg_file.sv
// reg_file: 8-entry register file, two combinational reads, one synchronous write, sync clear
module reg_file #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [2:0]        raddr2,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] mem_q [8];
    logic [DATA_W-1:0] mem_d [8];

    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];

    // merge the pending write into the next register image
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    // reset clears every entry and takes priority over the write
    always_ff @(posedge clk) begin
        if (rst) mem_q <= '{default: '0};
        else     mem_q <= mem_d;
    end
endmodule

// File: rtl/cpu_core.sv
// cpu_core: single-cycle fetch/decode/writeback core driving an external ALU.
// Optional j/beq support is enabled by defining CPU_BRANCH_EN.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int              DATA_W   = CPU_DATA_W,
    parameter int              PC_W     = CPU_PC_W,
    parameter logic [PC_W-1:0] PC_RESET = '0
) (
    input  logic CLK,
    input  logic RESET,
    cpu_if.master bus
);
    logic [7:0]        op;
    logic [2:0]        dest_idx;
    logic [2:0]        src1_idx;
    logic [7:0]        src2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              we;
    logic              is_wb;
    logic              is_beq;
    logic              op_valid;
    logic              br_taken;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   br_target;
    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;

    assign op       = bus.INSTRUCTION[OP_MSB:OP_LSB];
    assign dest_idx = bus.INSTRUCTION[DEST_LSB+2:DEST_LSB];
    assign src1_idx = bus.INSTRUCTION[SRC1_LSB+2:SRC1_LSB];
    assign src2     = bus.INSTRUCTION[SRC2_MSB:SRC2_LSB];
    assign pc_inc   = pc_q + PC_W'(4);

    reg_file #(.DATA_W(DATA_W)) u_rf (
        .clk    (CLK),
        .rst    (RESET),
        .we     (we),
        .waddr  (dest_idx),
        .wdata  (bus.ALURESULT),
        .raddr1 (src1_idx),
        .rdata1 (rd1),
        .raddr2 (src2[2:0]),
        .rdata2 (rd2)
    );

    // opcode classification; branch opcodes count as undefined unless enabled
    always_comb begin
        is_wb = op <= OP_OR;
`ifdef CPU_BRANCH_EN
        is_beq    = op == OP_BEQ;
        op_valid  = op <= OP_BEQ;
        br_taken  = op == OP_J || (is_beq && bus.ALURESULT == '0);
        br_target = pc_inc + {{(PC_W-10){bus.INSTRUCTION[DEST_MSB]}}, bus.INSTRUCTION[DEST_MSB:DEST_LSB], 2'b00};
`else
        is_beq    = 1'b0;
        op_valid  = is_wb;
        br_taken  = 1'b0;
        br_target = pc_inc;
`endif
    end

    // state and PC registers; reset wins over every update
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RUN;
            pc_q    <= PC_RESET;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // an undefined opcode in RUN parks the core with PC on the offending word
    always_comb begin
        state_d = (state_q == RUN && !op_valid) ? HALT : state_q;
        pc_d    = (state_q == HALT || !op_valid) ? pc_q : br_taken ? br_target : pc_inc;
    end

    // operand, ALU select and writeback enable decode
    always_comb begin
        we           = state_q == RUN && is_wb;
        bus.PC       = pc_q;
        bus.HALTED   = state_q == HALT;
        bus.OPERAND1 = rd1;
        bus.OPERAND2 = op == OP_LOADI ? DATA_W'(src2) :
                       (op == OP_SUB || is_beq) ? DATA_W'(~rd2 + 1'b1) : rd2;
        bus.ALUOP    = state_q == HALT ? ALU_FWD :
                       (op == OP_ADD || op == OP_SUB || is_beq) ? ALU_ADD :
                       op == OP_AND ? ALU_AND :
                       op == OP_OR  ? ALU_OR  : ALU_FWD;
    end
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed plus random instruction stream checked against an architectural model
`timescale 1ns/1ps
module tb_cpu_core;
`ifdef CPU_BRANCH_EN
    localparam bit HAS_BR = 1'b1;
`else
    localparam bit HAS_BR = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET;
    int   n_checks = 0;
    int   n_pass = 0;

    int          m_r [8];
    logic [31:0] m_pc;
    bit          m_halt;

    cpu_if bus ();

    cpu_core u_core (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    alu u_alu (
        .OPERAND1  (bus.OPERAND1),
        .OPERAND2  (bus.OPERAND2),
        .ALUOP     (bus.ALUOP),
        .ALURESULT (bus.ALURESULT)
    );

    always #20 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk(input int op, input int d, input int s1, input int s2);
        return {8'(op), 8'(d), 8'(s1), 8'(s2)};
    endfunction

    task automatic model_reset();
        foreach (m_r[i]) m_r[i] = 0;
        m_pc   = 32'd0;
        m_halt = 1'b0;
    endtask

    task automatic sweep_regs();
        for (int i = 0; i < 8; i++) begin
            bus.INSTRUCTION = mk(1, 0, i, 0);
            #1;
            check($sformatf("R%0d", i), 32'(bus.OPERAND1), m_r[i]);
        end
    endtask

    task automatic cycle(input logic [31:0] ins, input logic rst);
        int op, d, s1, s2, a, b, e2, off;
        bit chk2;
        logic [2:0] eop;
        op = int'(ins[31:24]);
        d  = int'(ins[23:16]);
        s1 = int'(ins[15:8]);
        s2 = int'(ins[7:0]);
        a  = m_r[s1 % 8];
        b  = m_r[s2 % 8];
        off = int'($signed(ins[23:16]));
        RESET = rst;
        bus.INSTRUCTION = ins;
        #1;
        chk2 = 1'b1;
        e2 = 0;
        if (op == 0) e2 = s2;
        else if (op == 3 || op == 7) begin e2 = (256 - b) % 256; chk2 = op == 3 || HAS_BR; end
        else if (op <= 5) e2 = b;
        else chk2 = 1'b0;
        eop = 3'b000;
        if (!m_halt) begin
            if (op == 2 || op == 3 || (op == 7 && HAS_BR)) eop = 3'b001;
            else if (op == 4) eop = 3'b010;
            else if (op == 5) eop = 3'b011;
        end
        check("PC", bus.PC, m_pc);
        check("HALTED", 32'(bus.HALTED), 32'(m_halt));
        check("ALUOP", 32'(bus.ALUOP), 32'(eop));
        check("OPERAND1", 32'(bus.OPERAND1), a);
        if (chk2 && !m_halt) check("OPERAND2", 32'(bus.OPERAND2), e2);
        @(posedge CLK);
        if (rst) model_reset();
        else if (!m_halt) begin
            if (!(op <= 5 || (HAS_BR && op <= 7))) m_halt = 1'b1;
            else if (op == 6) m_pc = m_pc + 32'(4 + off * 4);
            else if (op == 7) m_pc = m_pc + 32'(a == b ? 4 + off * 4 : 4);
            else begin
                case (op)
                    0: m_r[d % 8] = s2;
                    1: m_r[d % 8] = b;
                    2: m_r[d % 8] = (a + b) % 256;
                    3: m_r[d % 8] = (a - b + 256) % 256;
                    4: m_r[d % 8] = a & b;
                    default: m_r[d % 8] = a | b;
                endcase
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
        RESET = 1'b0;
        sweep_regs();
    endtask

    initial begin
        int r, op;
        logic [31:0] ins;
        RESET = 1'b1;
        bus.INSTRUCTION = 32'd0;
        @(posedge CLK);
        model_reset();
        #1;
        RESET = 1'b0;
        check("reset PC", bus.PC, 32'd0);
        check("reset HALTED", 32'(bus.HALTED), 32'd0);
        sweep_regs();

        cycle(mk(0, 1, 0, 5), 0);
        cycle(mk(0, 2, 0, 3), 0);
        cycle(mk(2, 3, 1, 2), 0);
        cycle(mk(3, 4, 2, 1), 0);
        cycle(mk(8'h0F, 0, 0, 0), 0);
        for (int i = 0; i < 5; i++) cycle(mk(0, 1, 0, 8'h77), 0);
        cycle(mk(0, 0, 0, 0), 1);
        cycle(mk(0, 1, 0, 5), 0);
        cycle(mk(0, 2, 0, 3), 0);
        cycle(mk(4, 5, 1, 2), 0);
        cycle(mk(5, 6, 1, 2), 0);
        cycle(mk(1, 7, 0, 1), 0);
        cycle(mk(0, 1, 0, 8'hAA), 1);
        cycle(mk(0, 1, 0, 8'h80), 0);
        cycle(mk(2, 1, 1, 1), 0);
        cycle(mk(0, 9, 0, 8'h33), 0);
        cycle(mk(0, 0, 0, 0), 1);
        cycle(mk(0, 1, 0, 8'h11), 0);
        cycle(mk(0, 2, 0, 8'h22), 0);
        cycle(mk(7, 8'hFE, 1, 1), 0);
        cycle(mk(6, 3, 0, 0), 0);
        cycle(mk(0, 0, 0, 0), 1);

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            op = r < 80 ? int'($urandom_range(0, 5)) : r < 92 ? int'($urandom_range(6, 7)) : int'($urandom_range(8, 255));
            ins = mk(op, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            if (op == 7 && $urandom_range(0, 1) == 1) ins[7:0] = ins[15:8];
            cycle(ins, m_halt && $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cpu_core.md
# cpu_core

Instruction-side counterpart of the 8-bit ALU: fetches a 32-bit instruction word each cycle, decodes it, reads operands from an internal 8×8 register file, drives the ALU's OPERAND1/OPERAND2/ALUOP inputs, and writes ALURESULT back on the next clock edge. It advances the program counter and halts on an undefined opcode. It sits between instruction memory and the existing `alu`, forming the single-cycle datapath.

## Interface
- DATA_W, 8, register and ALU operand width
- PC_W, 32, program counter width
- PC_RESET, 0, PC value loaded on reset
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- INSTRUCTION  in  32  instruction at address PC; fields OP[31:24], DEST[23:16], SRC1[15:8], SRC2/IMM[7:0]
- PC  out  PC_W  address of current instruction
- OPERAND1  out  DATA_W  to ALU
- OPERAND2  out  DATA_W  to ALU
- ALUOP  out  3  to ALU: 000 FORWARD (passes OPERAND2), 001 ADD, 010 AND, 011 OR
- ALURESULT  in  DATA_W  from ALU, combinational in the same cycle
- HALTED  out  1  high while in HALT state

## Operation
- Opcodes: 0 loadi, 1 mov, 2 add, 3 sub, 4 and, 5 or; 6 j and 7 beq only with branch feature; everything else undefined.
- OPERAND1 = R[SRC1] for every opcode.
- OPERAND2: loadi → IMM; mov/add/and/or → R[SRC2]; sub/beq → (~R[SRC2] + 1) mod 256.
- ALUOP: loadi/mov → 000; add/sub/beq → 001; and → 010; or → 011; j/undefined → 000.
- Writeback R[DEST] ← ALURESULT at the rising edge for opcodes 0–5 only. DEST == SRC reads the old value; the new value appears after the edge.
- Arithmetic is modulo 2^8. No carry or overflow is produced.
- State machine has two states, RUN and HALT:
  - RUN → HALT when an undefined opcode is present at the edge. That instruction performs no writeback, and PC holds its address.
  - HALT holds PC and all registers, drives ALUOP = 000, and sets HALTED = 1. It leaves only through RESET.
- Register reads are combinational; the register file is 8 entries, addressed by the low 3 bits of each field (upper bits ignored).

## Timing
- Reset, on a rising edge with RESET = 1: PC = PC_RESET, R0–R7 = 0, state = RUN, HALTED = 0. OPERAND1 = 0 afterwards; other outputs follow the decode of INSTRUCTION.
- RESET overrides writeback, PC update and HALT. Reset mid-program or in HALT restarts from PC_RESET next cycle.
- One instruction per cycle. In RUN, PC ← PC + 4 at every edge unless a branch is taken. PC wraps modulo 2^PC_W.
- Latency: decode and operand outputs are combinational from INSTRUCTION and PC. Results are visible in registers one edge later.

## Configuration
- CPU_BRANCH_EN defined:
  - j: PC ← PC + 4 + (sign-extended DEST × 4), no writeback.
  - beq: computes R[SRC1] − R[SRC2] through the ALU. If ALURESULT == 0, PC ← PC + 4 + (sext(DEST) × 4), else PC + 4. No writeback.
  - Branch offsets use 8-bit two's complement, range −128..+127 words.
- CPU_BRANCH_EN undefined: opcodes 6 and 7 are undefined and enter HALT.

## Structure
- Package `cpu_pkg`: opcode constants, ALUOP constants (ALU_FWD, ALU_ADD, ALU_AND, ALU_OR), instruction field bit positions, and the state enum (RUN, HALT).
- Sub-module `reg_file`: 8 × DATA_W, two combinational read ports, one write port with enable, synchronous active-high reset clearing all entries.
- `cpu_core` holds the PC, the state register and the decode logic. The bench instantiates `alu` alongside it.

## Test plan
- Reset then loadi R1,5; loadi R2,3; add R3,R1,R2 → R3 = 8, PC = 12 after 3 edges.
- sub R4,R2,R1 with R1 = 5, R2 = 3 → OPERAND2 = 0xFB, R4 = 0xFE; and R5,R1,R2 → 1; or R6,R1,R2 → 7; mov R7,R1 → 5.
- Opcode 0x0F at PC = 16 → HALTED = 1 next cycle, PC stays 16, registers unchanged for 5 cycles. RESET → PC = 0, HALTED = 0.
- RESET asserted in the same cycle as loadi R1,0xAA → R1 = 0, PC = 0.
- With CPU_BRANCH_EN: beq offset −2 at PC = 8, registers equal → PC = 4. j offset +3 at PC = 4 → PC = 20. Without the macro, opcode 6 → HALT.
- add R1,R1,R1 with R1 = 0x80 → R1 = 0x00 (wrap). loadi R9-encoded DEST = 0x09 → writes R1.
